fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the CPU: program counter, next-PC selection with stall and branch redirect, synchronous instruction-memory addressing, and the IF/ID pipeline register feeding decode. It sits between the instruction ROM (1-cycle registered read) and the decode stage. It adds stall hold, flush on redirect, absolute or PC-relative targets, a boot bubble and a fetched-instruction counter.

## Interface
- `PC_W`, 16: program counter width.
- `INSTR_W`, 16: instruction width.
- `ADDR_W`, 8: instruction-memory address width; uses `pc[ADDR_W-1:0]`, requires `ADDR_W <= PC_W`.
- `PC_STEP`, 1: sequential PC increment.
- `RESET_PC`, 0: PC value after reset.
- `CNT_W`, 32: width of `fetch_count`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode cannot accept; hold PC and the IF/ID register.
- `redirect`  in  1  change of flow; load new PC and flush IF/ID.
- `redirect_rel`  in  1  1: target = `if_pc + sext(redirect_offset)`; 0: target = `redirect_target`.
- `redirect_target`  in  PC_W  absolute target.
- `redirect_offset`  in  PC_W  signed two's-complement offset.
- `imem_addr`  out  ADDR_W  address to the ROM; combinational from next-PC.
- `imem_rdata`  in  INSTR_W  ROM data for the address presented on the previous edge.
- `if_valid`  out  1  IF/ID holds a valid instruction.
- `if_instr`  out  INSTR_W  instruction to decode.
- `if_pc`  out  PC_W  PC of `if_instr`.
- `fetch_count`  out  CNT_W  number of instructions loaded into IF/ID as valid.

## Operation
- FSM has 2 states, `BOOT` and `RUN`. `reset` forces `BOOT`, `pc_q = RESET_PC`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `fetch_count = 0`.
- In `BOOT`:
  - `imem_addr = pc_q[ADDR_W-1:0]`; pc holds.
  - IF/ID stays invalid.
  - Unconditional transition to `RUN`. `stall` and `redirect` are ignored.
- In `RUN`, `imem_rdata` is the instruction at `pc_q`. Next-PC priority:
  1. `redirect`: next-PC = target.
  2. `stall`: next-PC = `pc_q`.
  3. Otherwise: next-PC = `pc_q + PC_STEP`.
- `imem_addr = next_pc[ADDR_W-1:0]` and `pc_q <= next_pc` each `RUN` cycle.
- IF/ID update in `RUN`:
  - `redirect`: `if_valid <= 0`. Flush wins over `stall`; `if_instr`/`if_pc` are don't-care but hold.
  - Else `stall`: all IF/ID fields hold.
  - Else: `if_valid <= 1`, `if_instr <= imem_rdata`, `if_pc <= pc_q`, `fetch_count += 1`.
- The redirect target lands in `pc_q` with no extra bubble. The wrong-path instruction is dropped, so decode sees exactly one invalid cycle.
- All PC arithmetic is modulo 2^PC_W:
  - `pc_q + PC_STEP` at all-ones wraps to `PC_STEP-1`.
  - Relative targets wrap the same way.
  - `imem_addr` wraps modulo 2^ADDR_W.
- `fetch_count` wraps at 2^CNT_W with no saturation.
- Reset mid-operation discards everything in flight; the next edge is identical to power-on reset.

## Timing
- Reset released before edge E0; cycle after E0 is `BOOT` with `imem_addr = RESET_PC`.
- `RUN` begins after E1; `if_valid = 1`, `if_pc = RESET_PC` after E2. First-instruction latency from reset release is 2 edges.
- Steady state: one instruction per cycle into IF/ID.
- `stall` seen at edge E holds IF/ID and PC at E. Because ROM re-reads `pc_q`, release resumes with no loss or duplication.
- `redirect` seen at edge E gives `if_valid = 0` after E. The target instruction is in IF/ID after E+1, unless stalled.
- `imem_addr` has a combinational path from `stall`, `redirect`, `redirect_rel`, `redirect_target` and `redirect_offset`; no path to `imem_rdata`.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum {`BOOT`, `RUN`}.
- Package `fetch_pkg`: `ifid_t` struct {valid, instr, pc}, parametrised via package parameters for default widths.
- Sub-module `if_id_reg`: IF/ID register with load, hold and flush controls and synchronous reset. The FSM, next-PC mux and counter stay in `fetch_unit`.

## Test plan
- Reset, then run with ROM[i] = 0xA000+i. Required: cycle after E2 shows `if_pc = 0`, `if_instr = 0xA000`; then pc 1, 2, 3 on consecutive cycles; `fetch_count = 3` after E4.
- Assert `stall` for 3 cycles while `if_pc = 5`. Required: `if_pc = 5` and `if_instr = 0xA005` held; `fetch_count` frozen; after release, `if_pc = 6` next, no duplicate.
- Absolute redirect to 0x0040 while `pc_q = 0x0010`. Required: one cycle `if_valid = 0`, then `if_pc = 0x40`, `if_instr = ROM[0x40]`.
- Relative redirect with `if_pc = 0x0020` and offset 0xFFF0 (-16). Required: next valid `if_pc = 0x0010`. Also check offset +2 with `if_pc = 0xFFFF`, which gives 0x0001.
- `redirect` and `stall` in the same cycle. Required: flush wins, `if_valid = 0`. Then reset asserted mid-stream gives all outputs 0, followed by the boot sequence again.
- Sequential run from `pc_q = 0xFFFE` with `ADDR_W = 8`. Required: `if_pc` sequence 0xFFFE, 0xFFFF, 0x0000; `imem_addr` sequence 0xFE, 0xFF, 0x00.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding and the
// IF/ID pipeline record at the default datapath widths.
package fetch_pkg;

   parameter int PC_W_DEF    = 16;
   parameter int INSTR_W_DEF = 16;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic                   valid;
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pc;
   } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, load captures a new
// instruction, otherwise every field holds.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [PC_W-1:0]    pc_d,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc
);

   // Flush only drops valid; instr/pc keep their old contents so that a
   // following PC-relative redirect still has a defined base.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_d;
         pc    <= pc_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection with stall and
// redirect, ROM addressing and the IF/ID register feeding decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W     = 16,
   parameter int INSTR_W  = 16,
   parameter int ADDR_W   = 8,
   parameter int PC_STEP  = 1,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect,
   input  logic               redirect_rel,
   input  logic [PC_W-1:0]    redirect_target,
   input  logic [PC_W-1:0]    redirect_offset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic [CNT_W-1:0]   fetch_count
);

   fetch_state_t      state_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   next_pc;
   logic [PC_W-1:0]   target;
   logic              running;
   logic              ifid_load;
   logic              ifid_flush;

   assign running    = (state_q == RUN);
   assign ifid_flush = running && redirect;
   assign ifid_load  = running && !redirect && !stall;

   // Offset has the full PC width, so sign extension is implicit and the
   // sum wraps modulo 2^PC_W like the sequential increment.
   always_comb begin
      target  = redirect_rel ? (if_pc + redirect_offset) : redirect_target;
      next_pc = pc_q;
      if (running) begin
         if (redirect)
            next_pc = target;
         else if (!stall)
            next_pc = pc_q + PC_W'(PC_STEP);
      end
   end

   assign imem_addr = next_pc[ADDR_W-1:0];

   // In BOOT next_pc equals pc_q, so the ROM fetches RESET_PC once before
   // RUN; a stall re-presents pc_q so nothing is lost or repeated.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BOOT;
         pc_q        <= PC_W'(RESET_PC);
         fetch_count <= '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= RUN;
            end
            RUN: begin
               pc_q <= next_pc;
               if (ifid_load)
                  fetch_count <= fetch_count + CNT_W'(1);
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (ifid_load),
      .flush   (ifid_flush),
      .instr_d (imem_rdata),
      .pc_d    (pc_q),
      .valid   (if_valid),
      .instr   (if_instr),
      .pc      (if_pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a registered ROM model
// where ROM[a] = 0xA000 + a.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic        redirect_rel;
   logic [15:0] redirect_target;
   logic [15:0] redirect_offset;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [31:0] fetch_count;

   int tests_run = 0;
   int tests_failed = 0;

   fetch_unit #(
      .PC_W(16), .INSTR_W(16), .ADDR_W(8), .PC_STEP(1), .RESET_PC(0), .CNT_W(32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_rel    (redirect_rel),
      .redirect_target (redirect_target),
      .redirect_offset (redirect_offset),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      imem_rdata <= 16'hA000 + {8'h00, imem_addr};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string name, input logic ev, input logic [15:0] epc,
                             input logic [15:0] einstr);
      tests_run++;
      if (if_valid !== ev || (ev && (if_pc !== epc || if_instr !== einstr))) begin
         tests_failed++;
         $display("[TB] FAIL %s: valid=%b pc=%h instr=%h, expected valid=%b pc=%h instr=%h",
                  name, if_valid, if_pc, if_instr, ev, epc, einstr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_rel = 1'b0;
      redirect_target = 16'h0; redirect_offset = 16'h0;
      step(); step();
      tests_run++;
      if (if_valid !== 1'b0 || if_instr !== 16'h0 || if_pc !== 16'h0 || fetch_count !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: valid=%b instr=%h pc=%h count=%0d, expected all 0",
                  if_valid, if_instr, if_pc, fetch_count);
      end
      tests_run++;
      if (imem_addr !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_addr: imem_addr=%h, expected 00", imem_addr);
      end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      step();
      check_ifid("boot_bubble", 1'b0, 16'h0, 16'h0);
      step();
      check_ifid("first_instr", 1'b1, 16'h0000, 16'hA000);
      for (int i = 1; i <= 5; i++) begin
         step();
         check_ifid($sformatf("seq_pc%0d", i), 1'b1, 16'(i), 16'hA000 + 16'(i));
         if (i == 2) begin
            tests_run++;
            if (fetch_count !== 32'd3) begin
               tests_failed++;
               $display("[TB] FAIL count_after_E4: count=%0d, expected 3", fetch_count);
            end
         end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      #1;
      tests_run++;
      if (imem_addr !== 8'h06) begin
         tests_failed++;
         $display("[TB] FAIL stall_addr: imem_addr=%h, expected 06", imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall_hold", 1'b1, 16'h0005, 16'hA005);
         tests_run++;
         if (fetch_count !== 32'd6) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: count=%0d, expected 6", fetch_count);
         end
      end
      stall = 1'b0;
      step();
      check_ifid("stall_release", 1'b1, 16'h0006, 16'hA006);
      tests_run++;
      if (fetch_count !== 32'd7) begin
         tests_failed++;
         $display("[TB] FAIL release_count: count=%0d, expected 7", fetch_count);
      end
   endtask

   task automatic test_redirect_abs();
      for (int i = 0; i < 9; i++) step();
      check_ifid("pre_redirect", 1'b1, 16'h000F, 16'hA00F);
      redirect = 1'b1; redirect_rel = 1'b0; redirect_target = 16'h0040;
      #1;
      tests_run++;
      if (imem_addr !== 8'h40) begin
         tests_failed++;
         $display("[TB] FAIL abs_addr: imem_addr=%h, expected 40", imem_addr);
      end
      step();
      redirect = 1'b0;
      check_ifid("abs_bubble", 1'b0, 16'h0, 16'h0);
      step();
      check_ifid("abs_target", 1'b1, 16'h0040, 16'hA040);
   endtask

   task automatic test_redirect_rel();
      redirect = 1'b1; redirect_rel = 1'b0; redirect_target = 16'h0020;
      step();
      redirect = 1'b0;
      step();
      check_ifid("rel_base", 1'b1, 16'h0020, 16'hA020);
      redirect = 1'b1; redirect_rel = 1'b1; redirect_offset = 16'hFFF0;
      step();
      redirect = 1'b0; redirect_rel = 1'b0;
      check_ifid("rel_bubble", 1'b0, 16'h0, 16'h0);
      step();
      check_ifid("rel_back16", 1'b1, 16'h0010, 16'hA010);
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_target = 16'hFFFE;
      #1;
      tests_run++;
      if (imem_addr !== 8'hFE) begin
         tests_failed++;
         $display("[TB] FAIL wrap_addr0: imem_addr=%h, expected FE", imem_addr);
      end
      step();
      redirect = 1'b0;
      #1;
      tests_run++;
      if (imem_addr !== 8'hFF) begin
         tests_failed++;
         $display("[TB] FAIL wrap_addr1: imem_addr=%h, expected FF", imem_addr);
      end
      step();
      check_ifid("wrap_fffe", 1'b1, 16'hFFFE, 16'hA0FE);
      tests_run++;
      if (imem_addr !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL wrap_addr2: imem_addr=%h, expected 00", imem_addr);
      end
      step();
      check_ifid("wrap_ffff", 1'b1, 16'hFFFF, 16'hA0FF);
      step();
      check_ifid("wrap_0000", 1'b1, 16'h0000, 16'hA000);
      // Relative +2 from 0xFFFF must wrap to 0x0001.
      redirect = 1'b1; redirect_target = 16'hFFFF;
      step();
      redirect = 1'b0;
      step();
      check_ifid("rel_wrap_base", 1'b1, 16'hFFFF, 16'hA0FF);
      redirect = 1'b1; redirect_rel = 1'b1; redirect_offset = 16'h0002;
      #1;
      tests_run++;
      if (imem_addr !== 8'h01) begin
         tests_failed++;
         $display("[TB] FAIL rel_wrap_addr: imem_addr=%h, expected 01", imem_addr);
      end
      step();
      redirect = 1'b0; redirect_rel = 1'b0;
      step();
      check_ifid("rel_wrap_target", 1'b1, 16'h0001, 16'hA001);
   endtask

   task automatic test_flush_stall();
      redirect = 1'b1; stall = 1'b1; redirect_target = 16'h0030;
      step();
      redirect = 1'b0; stall = 1'b0;
      check_ifid("flush_wins", 1'b0, 16'h0, 16'h0);
      step();
      check_ifid("flush_target", 1'b1, 16'h0030, 16'hA030);
   endtask

   task automatic test_reset_mid();
      step();
      reset = 1'b1;
      step();
      tests_run++;
      if (if_valid !== 1'b0 || if_instr !== 16'h0 || if_pc !== 16'h0 ||
          fetch_count !== 32'd0 || imem_addr !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset: valid=%b instr=%h pc=%h count=%0d addr=%h, expected all 0",
                  if_valid, if_instr, if_pc, fetch_count, imem_addr);
      end
      reset = 1'b0;
      step();
      check_ifid("reboot_bubble", 1'b0, 16'h0, 16'h0);
      step();
      check_ifid("reboot_first", 1'b1, 16'h0000, 16'hA000);
      tests_run++;
      if (fetch_count !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL reboot_count: count=%0d, expected 1", fetch_count);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_abs();
      test_redirect_rel();
      test_wrap();
      test_flush_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
